// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo path.
// Contents: parity mode constants, RX/TX FSM state encodings, and the
// bit-period helper used to size the baud counters.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_e;

  // Clock cycles per serial bit (integer divide).
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO used as the echo buffer.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   push, din        write strobe and data
//   pop              read strobe (caller never pops when empty)
//   dout             head entry, valid combinationally while !empty
//   full, empty      occupancy flags
//   level            current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracked separately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/uart_echo_fifo.sv
// UART loopback transceiver: received characters are checked, buffered and
// re-transmitted in order with the same frame format.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   rx               serial input (asynchronous, idle high)
//   tx               serial output (registered, idle high)
//   rx_frame_err     1-cycle pulse, stop bit sampled low
//   rx_parity_err    1-cycle pulse, parity mismatch
//   fifo_overflow    1-cycle pulse, good character dropped on a full FIFO
//   fifo_level       echo buffer occupancy
module uart_echo_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic                          tx,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          fifo_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  // ---------------------------------------------------------------- sync
  logic rx_meta_q;
  logic rx_s_q;

  // Two-flop synchronizer; resets to idle level so no false start after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------- fifo
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       push_c;
  logic       pop_c;

  // ---------------------------------------------------------------- rx
  rx_state_e        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_data_q;
  logic             rx_par_q;
  logic             rx_ferr_q;
  logic             rx_perr_q;
  logic             ovf_q;
  logic             rx_sample_c;
  logic             rx_stop_eval_c;
  logic             rx_par_ok_c;

  assign rx_sample_c    = (rx_cnt_q == CNT_LAST);
  assign rx_stop_eval_c = (rx_state_q == RX_STOP) && rx_sample_c;

  // Unused upper data bits are held at zero, so the full-byte XOR is the data parity.
  always_comb begin
    rx_par_ok_c = 1'b1;
    if (PARITY == PARITY_ODD) begin
      rx_par_ok_c = (^rx_data_q) ^ rx_par_q;
    end else if (PARITY == PARITY_EVEN) begin
      rx_par_ok_c = ~((^rx_data_q) ^ rx_par_q);
    end
  end

  // A simultaneous pop frees the slot, so a full FIFO still accepts the char.
  assign push_c = rx_stop_eval_c && rx_s_q && rx_par_ok_c && (!fifo_full || pop_c);

  // Receive FSM with registered error pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_data_q  <= '0;
      rx_par_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rx_ferr_q <= 1'b0;
      rx_perr_q <= 1'b0;
      ovf_q     <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == CNT_HALF) begin
            // High at mid start bit: glitch, silently ignore.
            if (rx_s_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_cnt_q   <= '0;
              rx_bit_q   <= '0;
              rx_data_q  <= '0;
              rx_state_q <= RX_DATA;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_sample_c) begin
            rx_cnt_q            <= '0;
            rx_data_q[rx_bit_q] <= rx_s_q;
            if (rx_bit_q == BIT_LAST) begin
              rx_state_q <= (PARITY != PARITY_NONE) ? RX_PAR : RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_PAR: begin
          if (rx_sample_c) begin
            rx_cnt_q   <= '0;
            rx_par_q   <= rx_s_q;
            rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_sample_c) begin
            // Only the first stop bit is checked; back to IDLE immediately.
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (!rx_s_q) begin
              rx_ferr_q <= 1'b1;
            end else if (!rx_par_ok_c) begin
              rx_perr_q <= 1'b1;
            end else if (fifo_full && !pop_c) begin
              ovf_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .din   (rx_data_q),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // ---------------------------------------------------------------- tx
  tx_state_e        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             tx_par_q;
  logic             tx_stop_q;
  logic             tx_q;
  logic             tx_last_c;

  assign pop_c     = (tx_state_q == TX_IDLE) && !fifo_empty;
  assign tx_last_c = (tx_cnt_q == CNT_LAST);

  // Transmit FSM; tx is the registered line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            tx_shift_q <= fifo_dout;
            tx_par_q   <= (PARITY == PARITY_EVEN) ? ^fifo_dout : ~^fifo_dout;
            tx_q       <= 1'b0;
            tx_cnt_q   <= '0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_last_c) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_q       <= tx_shift_q[0];
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_last_c) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == BIT_LAST) begin
              if (PARITY != PARITY_NONE) begin
                tx_q       <= tx_par_q;
                tx_state_q <= TX_PAR;
              end else begin
                tx_q       <= 1'b1;
                tx_stop_q  <= 1'b0;
                tx_state_q <= TX_STOP;
              end
            end else begin
              tx_q       <= tx_shift_q[1];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_PAR: begin
          if (tx_last_c) begin
            tx_cnt_q   <= '0;
            tx_q       <= 1'b1;
            tx_stop_q  <= 1'b0;
            tx_state_q <= TX_STOP;
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_last_c) begin
            tx_cnt_q <= '0;
            if (tx_stop_q == STOP_LAST) begin
              tx_state_q <= TX_IDLE;
            end else begin
              tx_stop_q <= 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CNT_W'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx            = tx_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_parity_err = rx_perr_q;
  assign fifo_overflow = ovf_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: four instances cover 8N1, 7E2, and depth-4 FIFOs
// at 8N1 and 8N2. Expected echoes are queued at stimulus time and compared
// when a frame is decoded from the selected instance's tx line.
module tb_uart_echo_fifo;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int          CPB      = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rx_v;
  logic [3:0] tx_v;
  logic [3:0] ferr_v;
  logic [3:0] perr_v;
  logic [3:0] ovf_v;
  logic [4:0] lvl_a;
  logic [4:0] lvl_b;
  logic [2:0] lvl_c;
  logic [2:0] lvl_d;

  always #5 clk = ~clk;

  uart_echo_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[0]), .tx(tx_v[0]), .rx_frame_err(ferr_v[0]),
    .rx_parity_err(perr_v[0]), .fifo_overflow(ovf_v[0]), .fifo_level(lvl_a));

  uart_echo_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[1]), .tx(tx_v[1]), .rx_frame_err(ferr_v[1]),
    .rx_parity_err(perr_v[1]), .fifo_overflow(ovf_v[1]), .fifo_level(lvl_b));

  uart_echo_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[2]), .tx(tx_v[2]), .rx_frame_err(ferr_v[2]),
    .rx_parity_err(perr_v[2]), .fifo_overflow(ovf_v[2]), .fifo_level(lvl_c));

  uart_echo_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .rst_n(rst_n), .rx(rx_v[3]), .tx(tx_v[3]), .rx_frame_err(ferr_v[3]),
    .rx_parity_err(perr_v[3]), .fifo_overflow(ovf_v[3]), .fifo_level(lvl_d));

  // Selected instance and its frame format
  logic [1:0] sel;
  int         cfg_nb;
  int         cfg_par;   // 0 none, 1 odd, 2 even
  int         cfg_stop;
  logic       tx_s;
  logic [7:0] lvl_s;

  assign tx_s = tx_v[sel];

  always_comb begin
    case (sel)
      2'd0:    lvl_s = 8'(lvl_a);
      2'd1:    lvl_s = 8'(lvl_b);
      2'd2:    lvl_s = 8'(lvl_c);
      default: lvl_s = 8'(lvl_d);
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and monitor state
  logic [7:0] exp_q[$];
  logic       mon_en   = 1'b0;
  logic       mon_ign  = 1'b0;   // discard decoded frames (reset test)
  logic       mon_skip = 1'b0;   // allow dropped entries (overflow test)
  int         mon_drop = 0;
  logic [7:0] mon_d;
  logic       mon_p;
  logic       mon_start;
  int         mon_hi;
  logic [7:0] mon_e;

  // Pulse / level statistics for the selected instance
  int         n_ferr = 0;
  int         n_perr = 0;
  int         n_ovf  = 0;
  int         n_txlow = 0;
  int         lvl_max = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ferr_v[sel] === 1'b1) n_ferr++;
      if (perr_v[sel] === 1'b1) n_perr++;
      if (ovf_v[sel] === 1'b1) n_ovf++;
      if (tx_s === 1'b0) n_txlow++;
      if (int'(lvl_s) > lvl_max) lvl_max = int'(lvl_s);
    end
  end

  // Decode frames from tx: k=0 is the first low sample, bit i mid at 15+10i.
  always begin : mon
    @(negedge clk);
    if (mon_en && tx_s === 1'b0) begin
      mon_d = '0;
      mon_p = 1'b0;
      repeat (5) @(negedge clk);
      mon_start = tx_s;
      for (int i = 0; i < cfg_nb; i++) begin
        repeat (CPB) @(negedge clk);
        mon_d[i] = tx_s;
      end
      if (cfg_par != 0) begin
        repeat (CPB) @(negedge clk);
        mon_p = tx_s;
      end
      repeat (5) @(negedge clk);
      mon_hi = 0;
      for (int i = 0; i < cfg_stop * CPB; i++) begin
        if (i != 0) @(negedge clk);
        if (tx_s === 1'b1) mon_hi++;
      end
      if (!mon_ign) begin
        check_eq("echo_start_bit", 32'(mon_start), 32'd0);
        check_eq("echo_stop_len", 32'(mon_hi), 32'(cfg_stop * CPB));
        if (mon_skip) begin
          while (exp_q.size() != 0 && exp_q[0] != mon_d) begin
            void'(exp_q.pop_front());
            mon_drop++;
          end
        end
        if (exp_q.size() == 0) begin
          check_eq("echo_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("echo_data", 32'(mon_d), 32'(mon_e));
          if (cfg_par == 2) check_eq("echo_parity", 32'(mon_p), 32'(^mon_e));
          if (cfg_par == 1) check_eq("echo_parity", 32'(mon_p), 32'(~^mon_e));
        end
      end
    end
  end

  task automatic set_cfg(input logic [1:0] s, input int nb, input int par, input int stp);
    sel      = s;
    cfg_nb   = nb;
    cfg_par  = par;
    cfg_stop = stp;
  endtask

  task automatic clr_stats();
    @(posedge clk);
    n_ferr = 0; n_perr = 0; n_ovf = 0; n_txlow = 0; lvl_max = 0; mon_drop = 0;
    @(negedge clk);
  endtask

  // Drive one frame on the selected rx line; stop level held stop_clks, then idle.
  task automatic send_frame(input logic [7:0] d, input logic par_flip,
                            input logic stop_v, input int stop_clks);
    logic p;
    logic [7:0] m;
    m = d & 8'((1 << cfg_nb) - 1);
    rx_v[sel] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < cfg_nb; i++) begin
      rx_v[sel] = m[i];
      repeat (CPB) @(negedge clk);
    end
    if (cfg_par != 0) begin
      p = (cfg_par == 2) ? ^m : ~^m;
      rx_v[sel] = p ^ par_flip;
      repeat (CPB) @(negedge clk);
    end
    rx_v[sel] = stop_v;
    repeat (stop_clks) @(negedge clk);
    rx_v[sel] = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] d, input int stop_clks);
    if (!mon_ign) exp_q.push_back(d);
    send_frame(d, 1'b0, 1'b1, stop_clks);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag, input int ferr, input int perr, input int ovf);
    check_eq({tag, "_ferr"}, 32'(n_ferr), 32'(ferr));
    check_eq({tag, "_perr"}, 32'(n_perr), 32'(perr));
    check_eq({tag, "_ovf"}, 32'(n_ovf), 32'(ovf));
    check_eq({tag, "_lvl"}, 32'(lvl_s), 32'd0);
  endtask

  initial begin
    int n;
    rx_v  = 4'hF;
    rst_n = 1'b0;
    set_cfg(2'd0, 8, 0, 1);
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(tx_v), 32'hF);
    check_eq("rst_lvl", 32'(lvl_s), 32'd0);
    check_eq("rst_pulses", 32'({ferr_v, perr_v, ovf_v}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    mon_en = 1'b1;

    // 8N1 basic echo
    clr_stats();
    send_good(8'hA5, CPB);
    drain("t1_drain");
    check_quiet("t1", 0, 0, 0);

    // 7E2: good parity echoes, bad parity is flagged and dropped
    set_cfg(2'd1, 7, 2, 2);
    clr_stats();
    send_good(8'h41, 2 * CPB);
    drain("t2_drain");
    send_frame(8'h41, 1'b1, 1'b1, 2 * CPB);
    repeat (300) @(negedge clk);
    check_quiet("t2", 0, 1, 0);

    // 8N1 framing error then recovery
    set_cfg(2'd0, 8, 0, 1);
    clr_stats();
    send_frame(8'h3C, 1'b0, 1'b0, CPB);
    repeat (300) @(negedge clk);
    check_eq("t3_no_echo", 32'(n_txlow), 32'd0);
    send_good(8'h55, CPB);
    drain("t3_drain");
    check_quiet("t3", 1, 0, 0);

    // Depth 4, TX keeps pace: no overflow
    set_cfg(2'd2, 8, 0, 1);
    clr_stats();
    for (int i = 1; i <= 6; i++) send_good(8'(i), CPB);
    drain("t4a_drain");
    check_quiet("t4a", 0, 0, 0);

    // Depth 4, 8N2 TX slower than shortened-stop input: saturation and drops
    set_cfg(2'd3, 8, 0, 2);
    clr_stats();
    mon_skip = 1'b1;
    for (int i = 1; i <= 120; i++) send_good(8'(i), 9);
    n = 0;
    while (lvl_s != 8'd0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check_eq("t4b_lvl_drain", 32'(lvl_s), 32'd0);
    repeat (250) @(negedge clk);
    mon_drop = mon_drop + exp_q.size();
    exp_q.delete();
    mon_skip = 1'b0;
    check_eq("t4b_ovf_vs_drop", 32'(n_ovf), 32'(mon_drop));
    check_eq("t4b_ovf_seen", 32'(n_ovf != 0), 32'd1);
    check_eq("t4b_lvl_max", 32'(lvl_max), 32'd4);
    check_eq("t4b_ferr", 32'(n_ferr), 32'd0);

    // Glitch on rx: ignored
    set_cfg(2'd0, 8, 0, 1);
    clr_stats();
    rx_v[sel] = 1'b0;
    repeat (3) @(negedge clk);
    rx_v[sel] = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("t5_tx_idle", 32'(n_txlow), 32'd0);
    check_quiet("t5", 0, 0, 0);

    // Reset while echo in DATA with one char queued
    set_cfg(2'd3, 8, 0, 2);
    clr_stats();
    mon_ign = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(8'hE0 + 8'(i), 1'b0, 1'b1, 9);
    repeat (3) @(negedge clk);
    check_eq("t6_lvl_pre", 32'(lvl_s), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_tx", 32'(tx_s), 32'd1);
    check_eq("t6_rst_lvl", 32'(lvl_s), 32'd0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    mon_ign = 1'b0;
    clr_stats();
    send_good(8'h7E, 2 * CPB);
    drain("t6_drain");
    check_quiet("t6", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
